// File: rtl/gps_ca_pkg.sv
// Shared constants and types for the GPS L1 C/A code generator and mixer.
// Holds code length, LFSR geometry, feedback masks, default PRN 1 taps,
// the mix mode encoding and a tap range check used at tap latch time.
package gps_ca_pkg;

    localparam int CA_LEN = 1023;
    localparam int LFSR_W = 10;

    // Bit i-1 of the register holds stage i; a mask bit marks a feedback stage.
    // G1: 1 + x^3 + x^10 -> stages 3, 10.
    localparam logic [LFSR_W-1:0] G1_MASK = 10'b10_0000_0100;
    // G2: 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10 -> stages 2, 3, 6, 8, 9, 10.
    localparam logic [LFSR_W-1:0] G2_MASK = 10'b11_1010_0110;

    localparam logic [3:0] DEF_TAP_A = 4'd2;
    localparam logic [3:0] DEF_TAP_B = 4'd6;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_MIX    = 2'b01,
        MODE_CODE   = 2'b10,
        MODE_INV    = 2'b11
    } mix_mode_e;

    function automatic logic tap_ok(input logic [3:0] t);
        return (t != 4'd0) && (t <= 4'd10);
    endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 Gold code pair with latched PRN taps and chip output.
// Latency: state changes on the edge after shift_i/load_i; chip_o is a pure decode of registers.
// Ports: load_i restarts both LFSRs and latches taps, shift_i advances one chip,
//        chip_o is the current chip, tap_err_o flags an out-of-range latched tap.
module ca_lfsr_pair
    import gps_ca_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [3:0] tap_a_i,
    input  logic [3:0] tap_b_i,
    output logic       chip_o,
    output logic       tap_err_o
);

    logic [LFSR_W-1:0] g1_q;
    logic [LFSR_W-1:0] g2_q;
    logic [3:0]        tap_a_q;
    logic [3:0]        tap_b_q;
    logic              tap_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g1_q      <= '1;
            g2_q      <= '1;
            tap_a_q   <= DEF_TAP_A;
            tap_b_q   <= DEF_TAP_B;
            tap_err_q <= 1'b0;
        end else if (load_i) begin
            // A load always wins over a coincident shift.
            g1_q      <= '1;
            g2_q      <= '1;
            tap_a_q   <= tap_a_i;
            tap_b_q   <= tap_b_i;
            tap_err_q <= !(tap_ok(tap_a_i) && tap_ok(tap_b_i));
        end else if (shift_i) begin
            g1_q <= {g1_q[LFSR_W-2:0], ^(g1_q & G1_MASK)};
            g2_q <= {g2_q[LFSR_W-2:0], ^(g2_q & G2_MASK)};
        end
    end

    // Padding to 16 bits lets a 4-bit tap index any value without going out
    // of range; invalid taps are masked by tap_err_q anyway.
    logic [15:0] g2_ext;
    logic        sel_a;
    logic        sel_b;

    always_comb begin
        g2_ext = {6'b0, g2_q};
        sel_a  = g2_ext[tap_a_q - 4'd1];
        sel_b  = g2_ext[tap_b_q - 4'd1];
        chip_o = tap_err_q ? g1_q[LFSR_W-1] : (g1_q[LFSR_W-1] ^ sel_a ^ sel_b);
    end

    assign tap_err_o = tap_err_q;

endmodule

// File: rtl/ca_code_mixer.sv
// C/A code generator at a programmable chip rate, mixed into a registered sample stream.
// Latency: 1 cycle sample_in -> mix_out; load takes effect on the next cycle.
// No backpressure: sample_valid is a pure qualifier, every valid sample is mixed and forwarded.
// Ports: en gates the chip clock only, load restarts the code with new taps,
//        mode selects bypass/mix/code-only/inverted mix, chip_idx/epoch report code phase.
module ca_code_mixer
    import gps_ca_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int IN_W    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [3:0]      prn_tap_a,
    input  logic [3:0]      prn_tap_b,
    input  logic [1:0]      mode,
    input  logic            sample_valid,
    input  logic [IN_W-1:0] sample_in,
    output logic [IN_W-1:0] mix_out,
    output logic            mix_valid,
    output logic            code_chip,
    output logic [9:0]      chip_idx,
    output logic            epoch,
    output logic            tap_err
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [IN_W-1:0] S_ONE = IN_W'(1);
    localparam logic [IN_W-1:0] S_MIN = S_ONE << (IN_W - 1);
    localparam logic [IN_W-1:0] S_MAX = ~S_MIN;

    // ---------------- chip timing ----------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [9:0]       chip_idx_q;
    logic             epoch_q;
    logic             advance;

    assign advance = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            chip_idx_q <= '0;
            epoch_q    <= 1'b0;
        end else if (load) begin
            div_cnt_q  <= '0;
            chip_idx_q <= '0;
            epoch_q    <= 1'b0;
        end else begin
            // Only a natural 1022 -> 0 wrap produces an epoch pulse.
            epoch_q <= advance && (chip_idx_q == 10'(CA_LEN - 1));
            if (advance) begin
                div_cnt_q  <= '0;
                chip_idx_q <= (chip_idx_q == 10'(CA_LEN - 1)) ? 10'd0 : chip_idx_q + 10'd1;
            end else if (en) begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

    ca_lfsr_pair u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .shift_i   (advance),
        .tap_a_i   (prn_tap_a),
        .tap_b_i   (prn_tap_b),
        .chip_o    (code_chip),
        .tap_err_o (tap_err)
    );

    // ---------------- sample datapath ----------------
    logic [IN_W-1:0] mix_q;
    logic [IN_W-1:0] mix_d;
    logic            mix_valid_q;
    logic            chip_eff;
    logic [IN_W-1:0] neg_s;

    always_comb begin
        chip_eff = (mode == MODE_INV) ? ~code_chip : code_chip;
        // Negating the most negative value would overflow; clamp to max positive.
        neg_s    = (sample_in == S_MIN) ? S_MAX : (~sample_in + S_ONE);
        mix_d    = mix_q;
        if (sample_valid) begin
            unique case (mix_mode_e'(mode))
                MODE_BYPASS: mix_d = sample_in;
                MODE_MIX, MODE_INV: begin
                    if (IN_W == 1) mix_d = sample_in ^ {IN_W{chip_eff}};
                    else           mix_d = chip_eff ? neg_s : sample_in;
                end
                MODE_CODE: begin
                    if (IN_W == 1) mix_d = {IN_W{code_chip}};
                    else           mix_d = code_chip ? '1 : S_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            mix_q       <= mix_d;
            mix_valid_q <= sample_valid;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = mix_valid_q;
    assign chip_idx  = chip_idx_q;
    assign epoch     = epoch_q;

endmodule
